// File: rtl/fib_main_pkg.sv
// rtl/fib_main_pkg.sv - shared state encoding and default widths for the fib_main kernel
package fib_main_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_W_DEF = 6;
  localparam int D_W_DEF = 32;

endpackage

// File: rtl/fib_main_step.sv
// rtl/fib_main_step.sv - combinational (a,b) <- (a+b, a) step; FIB_MAIN_SATURATE_EN selects saturating add
module fib_main_step
  import fib_main_pkg::*;
#(
  parameter int D_W = D_W_DEF
) (
  input  logic [D_W-1:0] a,
  input  logic [D_W-1:0] b,
  output logic [D_W-1:0] a_next,
  output logic [D_W-1:0] b_next
);

`ifdef FIB_MAIN_SATURATE_EN
  logic [D_W:0] sum;

  // Widened add; a carry out pins the result to all-ones so a saturated value stays saturated
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    a_next = sum[D_W] ? {D_W{1'b1}} : sum[D_W-1:0];
    b_next = a;
  end
`else
  // Plain modular add; the carry out is deliberately dropped
  always_comb begin
    a_next = a + b;
    b_next = a;
  end
`endif

endmodule

// File: rtl/fib_main.sv
// rtl/fib_main.sv - iterative Fibonacci accumulator top (FSM, n counter, result strobe); option FIB_MAIN_SATURATE_EN
module fib_main
  import fib_main_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r_enable,
  input  logic           controlArr,
  input  logic [N_W-1:0] init_n,
  input  logic [D_W-1:0] init_a,
  input  logic [D_W-1:0] init_b,
  output logic           w_enable,
  output logic [D_W-1:0] result
);

  state_t         state_q, state_d;
  logic [N_W-1:0] n_q, n_d;
  logic [D_W-1:0] a_q, a_d;
  logic [D_W-1:0] b_q, b_d;
  logic [D_W-1:0] result_q, result_d;
  logic           w_enable_q, w_enable_d;

  logic [D_W-1:0] a_step;
  logic [D_W-1:0] b_step;

  fib_main_step #(
    .D_W(D_W)
  ) u_step (
    .a      (a_q),
    .b      (b_q),
    .a_next (a_step),
    .b_next (b_step)
  );

  // Next-state logic: start is level-sensitive in IDLE, hold freezes LOOP, DONE emits the strobe
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    w_enable_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (r_enable) begin
          n_d     = init_n;
          a_d     = init_a;
          b_d     = init_b;
          state_d = LOOP;
        end
      end
      LOOP: begin
        if (!controlArr) begin
          if (n_q == '0) begin
            state_d = DONE;
          end else begin
            a_d = a_step;
            b_d = b_step;
            n_d = n_q - N_W'(1);
          end
        end
      end
      DONE: begin
        result_d   = b_q;
        w_enable_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run without a strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      w_enable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      w_enable_q <= w_enable_d;
    end
  end

  assign w_enable = w_enable_q;
  assign result   = result_q;

endmodule

// File: tb/tb_fib_main.sv
// tb/tb_fib_main.sv - scoreboard bench for fib_main; expectations follow FIB_MAIN_SATURATE_EN
module tb_fib_main;

  localparam int N_W = 6;
  localparam int D_W = 32;

  typedef struct {
    logic [D_W-1:0] res;
    int             cyc;
    string          name;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           r_enable;
  logic           controlArr;
  logic [N_W-1:0] init_n;
  logic [D_W-1:0] init_a;
  logic [D_W-1:0] init_b;
  logic           w_enable;
  logic [D_W-1:0] result;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  fib_main #(
    .N_W(N_W),
    .D_W(D_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .r_enable   (r_enable),
    .controlArr (controlArr),
    .init_n     (init_n),
    .init_a     (init_a),
    .init_b     (init_b),
    .w_enable   (w_enable),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; at a negedge, cyc equals the number of edges so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [D_W-1:0] act, input logic [D_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, req, req);
  endtask

  // Pulse r_enable for one cycle; the following posedge samples it, strobe seen n+2 edges later
  task automatic start_run(input string name, input int n, input logic [D_W-1:0] a,
                           input logic [D_W-1:0] b, input logic [D_W-1:0] exp_res,
                           input int extra, input bit expect_strobe);
    exp_t e;
    @(negedge clk);
    r_enable = 1'b1;
    init_n   = N_W'(n);
    init_a   = a;
    init_b   = b;
    if (expect_strobe) begin
      e.res  = exp_res;
      e.cyc  = cyc + 1 + n + 2 + extra;
      e.name = name;
      exp_q.push_back(e);
    end
    @(negedge clk);
    r_enable = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d strobes still outstanding after %0d cycles", exp_q.size(), budget);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every strobe is matched against the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (w_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_strobe: strobe at cycle %0d with result %0d, expected none", cyc, result);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_cycle"}, D_W'(cyc), D_W'(e.cyc));
          @(negedge clk);
          check({e.name, "_width"}, D_W'(w_enable), '0);
        end
      end
    end
  end

  initial begin
    logic [D_W-1:0] exp48;
`ifdef FIB_MAIN_SATURATE_EN
    exp48 = 32'hFFFF_FFFF;
`else
    exp48 = 32'd512559680;
`endif
    cyc        = 0;
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    r_enable   = 1'b0;
    controlArr = 1'b0;
    init_n     = '0;
    init_a     = '0;
    init_b     = '0;
    repeat (3) @(negedge clk);
    check("reset_w_enable", D_W'(w_enable), '0);
    check("reset_result", result, '0);
    rst = 1'b0;

    // fib(40)
    start_run("fib40", 40, 32'd1, 32'd0, 32'd102334155, 0, 1'b1);
    wait_drain(100);

    // n=0 returns init_b after 2 cycles
    start_run("n0", 0, 32'd1, 32'd7, 32'd7, 0, 1'b1);
    wait_drain(20);

    // n=48 overflows 32 bits
    start_run("fib48", 48, 32'd1, 32'd0, exp48, 0, 1'b1);
    wait_drain(100);

    // n=10 with a 5-cycle hold mid-loop
    start_run("hold10", 10, 32'd1, 32'd0, 32'd55, 5, 1'b1);
    repeat (2) @(negedge clk);
    controlArr = 1'b1;
    repeat (5) @(negedge clk);
    controlArr = 1'b0;
    wait_drain(40);

    // reset mid-run aborts without a strobe
    start_run("abort40", 40, 32'd1, 32'd0, '0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_result", result, '0);
    start_run("after_abort_n1", 1, 32'd1, 32'd0, 32'd1, 0, 1'b1);
    wait_drain(20);

    // second start during LOOP must be ignored
    start_run("ignore10", 10, 32'd1, 32'd0, 32'd55, 0, 1'b1);
    repeat (3) @(negedge clk);
    r_enable = 1'b1;
    init_n   = 6'd3;
    init_a   = 32'd9;
    init_b   = 32'd9;
    @(negedge clk);
    r_enable = 1'b0;
    wait_drain(40);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
